// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter/sequencer for the unified memory port: IDLE -> ISSUE -> (WAIT) -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT lasts RD_LAT-1 cycles, so the counter starts at RD_LAT-2 and exits at zero.
  localparam logic [1:0] CNT_INIT = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t            state, state_next;
  logic [1:0]        cnt, cnt_next;
  logic              load;
  logic              winner;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_owner <= 1'b1;
    else if (state == ISSUE)
      last_owner <= owner;
  end

  // Tie goes to whoever did not own the port last; a lone requester always wins.
  always_comb begin
    winner = 1'b1;
    if (m0_req)
      winner = m1_req ? ~last_owner : 1'b0;
  end
`else
  assign winner = ~m0_req;
`endif

  assign sel_we    = winner ? m1_we    : m0_we;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_next = IDLE;
        end else if (RD_LAT > 1) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (cnt == 2'd0)
          state_next = RESP;
        else
          cnt_next = cnt - 2'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload is captured on the IDLE->ISSUE edge so mem_* are registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      mem_en_q <= load;
      mem_we_q <= load & sel_we;
      if (load) begin
        owner   <= winner;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy      = (state != IDLE);
  assign m0_gnt    = (state == ISSUE) && !owner;
  assign m1_gnt    = (state == ISSUE) &&  owner;
  assign m0_rvalid = (state == RESP)  && !owner;
  assign m1_rvalid = (state == RESP)  &&  owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_port_arbiter: three instances at RD_LAT 1, 2 and 4 with a latency-accurate memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  logic        m0_req   [3];
  logic        m0_we    [3];
  logic [31:0] m0_addr  [3];
  logic [31:0] m0_wdata [3];
  logic        m0_gnt   [3];
  logic        m0_rvalid[3];
  logic [31:0] m0_rdata [3];
  logic        m1_req   [3];
  logic        m1_we    [3];
  logic [31:0] m1_addr  [3];
  logic [31:0] m1_wdata [3];
  logic        m1_gnt   [3];
  logic        m1_rvalid[3];
  logic [31:0] m1_rdata [3];
  logic        mem_en   [3];
  logic        mem_we   [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic        busy     [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : (a * 32'd3 + 32'h1000);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] pipe [4];
    logic        pv   [4];
    logic [31:0] rd;

    // Read data appears exactly LAT cycles after the mem_en cycle; junk otherwise.
    always @(posedge clk) begin
      pipe[0] <= mem_val(mem_addr[g]);
      pv[0]   <= mem_en[g] & ~mem_we[g];
      for (int k = 1; k < 4; k++) begin
        pipe[k] <= pipe[k-1];
        pv[k]   <= pv[k-1];
      end
    end
    assign rd = pv[LAT-1] ? pipe[LAT-1] : 32'hBAD0BAD0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req[g]),
      .m0_we     (m0_we[g]),
      .m0_addr   (m0_addr[g]),
      .m0_wdata  (m0_wdata[g]),
      .m0_gnt    (m0_gnt[g]),
      .m0_rvalid (m0_rvalid[g]),
      .m0_rdata  (m0_rdata[g]),
      .m1_req    (m1_req[g]),
      .m1_we     (m1_we[g]),
      .m1_addr   (m1_addr[g]),
      .m1_wdata  (m1_wdata[g]),
      .m1_gnt    (m1_gnt[g]),
      .m1_rvalid (m1_rvalid[g]),
      .m1_rdata  (m1_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (rd),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m0_req[i] = 0; m0_we[i] = 0; m0_addr[i] = '0; m0_wdata[i] = '0;
      m1_req[i] = 0; m1_we[i] = 0; m1_addr[i] = '0; m1_wdata[i] = '0;
    end
    rst = 1'b1;
    step(); step(); step(); step();

    chk("rst_busy",   busy[0],     0);
    chk("rst_mem_en", mem_en[0],   0);
    chk("rst_mem_we", mem_we[0],   0);
    chk("rst_addr",   mem_addr[0], 0);
    chk("rst_gnt",    {m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0]}, 0);
    rst = 1'b0;
    step();

    // Simultaneous reads, RD_LAT=1: m0 first, m1 granted at T+4.
    m0_req[0] = 1; m0_we[0] = 0; m0_addr[0] = 32'h20;
    m1_req[0] = 1; m1_we[0] = 0; m1_addr[0] = 32'h30;
    step();
    chk("tie_m0_gnt",  m0_gnt[0],   1);
    chk("tie_m1_gnt0", m1_gnt[0],   0);
    chk("tie_addr0",   mem_addr[0], 32'h20);
    m0_req[0] = 0;
    step();
    chk("tie_m0_rvalid", m0_rvalid[0], 1);
    chk("tie_m0_rdata",  m0_rdata[0],  32'h1060);
    chk("tie_m1_rdata0", m1_rdata[0],  0);
    step();
    chk("tie_idle_busy", busy[0],   0);
    chk("tie_idle_gnt",  m1_gnt[0], 0);
    step();
    chk("tie_m1_gnt", m1_gnt[0],   1);
    chk("tie_addr1",  mem_addr[0], 32'h30);
    m1_req[0] = 0;
    step();
    chk("tie_m1_rvalid", m1_rvalid[0], 1);
    chk("tie_m1_rdata",  m1_rdata[0],  32'h1090);
    step();

    // m0 write on RD_LAT=1 instance.
    m0_req[0] = 1; m0_we[0] = 1; m0_addr[0] = 32'h10; m0_wdata[0] = 32'hDEADBEEF;
    step();
    chk("wr_gnt",   m0_gnt[0],    1);
    chk("wr_m1gnt", m1_gnt[0],    0);
    chk("wr_en",    mem_en[0],    1);
    chk("wr_we",    mem_we[0],    1);
    chk("wr_addr",  mem_addr[0],  32'h10);
    chk("wr_wdata", mem_wdata[0], 32'hDEADBEEF);
    m0_req[0] = 0;
    step();
    chk("wr_busy", busy[0],   0);
    chk("wr_en0",  mem_en[0], 0);

    // m1 read, RD_LAT=2.
    m1_req[1] = 1; m1_we[1] = 0; m1_addr[1] = 32'h40;
    step();
    chk("rd2_gnt", m1_gnt[1], 1);
    chk("rd2_en",  mem_en[1], 1);
    chk("rd2_we",  mem_we[1], 0);
    m1_req[1] = 0;
    step();
    chk("rd2_wait_rvalid", m1_rvalid[1], 0);
    chk("rd2_wait_busy",   busy[1],      1);
    step();
    chk("rd2_rvalid",    m1_rvalid[1], 1);
    chk("rd2_rdata",     m1_rdata[1],  32'h12345678);
    chk("rd2_m0_rvalid", m0_rvalid[1], 0);
    chk("rd2_m0_rdata",  m0_rdata[1],  0);
    step();
    chk("rd2_done", {busy[1], m1_rvalid[1]}, 0);

    // m1 write request arrives during m0 read, RD_LAT=2.
    m0_req[1] = 1; m0_we[1] = 0; m0_addr[1] = 32'h70;
    step();
    chk("ovl_m0_gnt", m0_gnt[1], 1);
    m0_req[1] = 0;
    m1_req[1] = 1; m1_we[1] = 1; m1_addr[1] = 32'h80; m1_wdata[1] = 32'h1111;
    step();
    chk("ovl_wait_gnt", m1_gnt[1], 0);
    step();
    chk("ovl_m0_rvalid", m0_rvalid[1], 1);
    chk("ovl_m0_rdata",  m0_rdata[1],  32'h1150);
    chk("ovl_resp_gnt",  m1_gnt[1],    0);
    step();
    chk("ovl_idle_gnt", m1_gnt[1], 0);
    step();
    chk("ovl_m1_gnt",   m1_gnt[1],    1);
    chk("ovl_m1_addr",  mem_addr[1],  32'h80);
    chk("ovl_m1_wdata", mem_wdata[1], 32'h1111);
    chk("ovl_m1_we",    mem_we[1],    1);
    m1_req[1] = 0;
    step();

    // Both requesting writes continuously on a fresh instance.
    m0_req[2] = 1; m0_we[2] = 1; m0_addr[2] = 32'h100; m0_wdata[2] = 32'hA0;
    m1_req[2] = 1; m1_we[2] = 1; m1_addr[2] = 32'h200; m1_wdata[2] = 32'hB0;
    for (int c = 1; c <= 8; c++) begin
      logic exp0, exp1;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      exp0 = (c % 4) == 1;
      exp1 = (c % 4) == 3;
`else
      exp0 = (c % 2) == 1;
      exp1 = 1'b0;
`endif
      chk($sformatf("cont_m0_gnt_c%0d", c), m0_gnt[2], exp0);
      chk($sformatf("cont_m1_gnt_c%0d", c), m1_gnt[2], exp1);
      if (exp0 || exp1)
        chk($sformatf("cont_addr_c%0d", c), mem_addr[2], exp1 ? 32'h200 : 32'h100);
    end
    m0_req[2] = 0; m1_req[2] = 0;
    step();

    // Reset during WAIT of an m0 read, RD_LAT=4.
    m0_req[2] = 1; m0_we[2] = 0; m0_addr[2] = 32'h50;
    step();
    chk("rst4_gnt", m0_gnt[2], 1);
    m0_req[2] = 0;
    step();
    chk("rst4_wait_busy", busy[2], 1);
    rst = 1'b1;
    #1;
    chk("rst4_async_outs", {busy[2], mem_en[2], mem_we[2], m0_gnt[2], m0_rvalid[2], m1_gnt[2], m1_rvalid[2]}, 0);
    chk("rst4_async_addr", mem_addr[2], 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst4_no_rvalid_c%0d", c), {m0_rvalid[2], busy[2]}, 0);
    end
    m1_req[2] = 1; m1_we[2] = 1; m1_addr[2] = 32'h60; m1_wdata[2] = 32'h77;
    step();
    chk("rst4_m1_gnt",  m1_gnt[2],   1);
    chk("rst4_m1_addr", mem_addr[2], 32'h60);
    chk("rst4_m1_we",   mem_we[2],   1);
    m1_req[2] = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
